dp_seq_ctrl: RTL and testbench

Host-side sequencer for the five-stage RV64 datapath. It loads instruction and data memory through their host ports and holds the datapath in reset while loading. It then runs the core for a bounded or unbounded number of instruction slots, gating `pc_en` only on 4-cycle fetch-slot boundaries, and drains the pipeline before reporting completion. It is the only driver of the datapath's `i_mem_*`, `d_mem_*`, `pc_en` and `reset_n` inputs.

---
 rtl/dp_seq_ctrl.sv | 207 ++++++++++++++++++++
 tb/tb_dp_seq_ctrl.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dp_seq_ctrl.sv
// Host-side sequencer for the five-stage RV64 datapath: loads imem/dmem, holds
// the core in reset while loading, runs it in 4-cycle fetch slots, then drains.
module dp_seq_ctrl #(
  parameter int PC_WIDTH     = 32,
  parameter int ISTR_WIDTH   = 32,
  parameter int D_WIDTH      = 64,
  parameter int CNT_WIDTH    = 16,
  parameter int DRAIN_CYCLES = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [1:0]            cmd_op,
  input  logic [PC_WIDTH-1:0]   cmd_addr,
  input  logic [D_WIDTH-1:0]    cmd_data,
  output logic [PC_WIDTH-1:0]   i_mem_addra,
  output logic [ISTR_WIDTH-1:0] i_mem_din,
  output logic                  i_mem_we,
  output logic [7:0]            d_mem_addra,
  output logic [D_WIDTH-1:0]    d_mem_din,
  output logic                  d_mem_we,
  output logic                  pc_en,
  output logic                  dp_reset_n,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [CNT_WIDTH-1:0]  slots_run
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_WRITE = 3'd1;
  localparam logic [2:0] S_CLEAR = 3'd2;
  localparam logic [2:0] S_RUN   = 3'd3;
  localparam logic [2:0] S_DRAIN = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;

  localparam logic [1:0] OP_WI   = 2'b00;
  localparam logic [1:0] OP_WD   = 2'b01;
  localparam logic [1:0] OP_RUN  = 2'b10;
  localparam logic [1:0] OP_STOP = 2'b11;

  // One counter serves both the 2-cycle CLEAR and the DRAIN_CYCLES drain.
  localparam int WAIT_W = (DRAIN_CYCLES > 2) ? $clog2(DRAIN_CYCLES) : 1;

  logic [2:0]            state_q, state_d;
  logic [WAIT_W-1:0]     wait_q, wait_d;
  logic [1:0]            phase_q, phase_d;
  logic [CNT_WIDTH-1:0]  n_q, n_d;
  logic [CNT_WIDTH-1:0]  slots_q, slots_d;
  logic                  stop_pend_q, stop_pend_d;
  logic                  cmd_ready_q, cmd_ready_d;
  logic [PC_WIDTH-1:0]   i_addr_q, i_addr_d;
  logic [ISTR_WIDTH-1:0] i_din_q, i_din_d;
  logic                  i_we_q, i_we_d;
  logic [7:0]            d_addr_q, d_addr_d;
  logic [D_WIDTH-1:0]    d_din_q, d_din_d;
  logic                  d_we_q, d_we_d;
  logic                  pc_en_q, pc_en_d;
  logic                  rstn_q, rstn_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  err_q, err_d;

  logic accept, stop_now, last_slot;

  assign accept    = cmd_valid & cmd_ready_q;
  assign stop_now  = accept && (cmd_op == OP_STOP);
  assign last_slot = (n_q != '0) && (slots_q == n_q - CNT_WIDTH'(1));

  always_comb begin
    state_d     = state_q;
    wait_d      = wait_q;
    phase_d     = phase_q;
    n_d         = n_q;
    slots_d     = slots_q;
    stop_pend_d = stop_pend_q;
    i_addr_d    = i_addr_q;
    i_din_d     = i_din_q;
    d_addr_d    = d_addr_q;
    d_din_d     = d_din_q;
    i_we_d      = 1'b0;
    d_we_d      = 1'b0;
    err_d       = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          case (cmd_op)
            OP_WI: begin
              i_addr_d = cmd_addr;
              i_din_d  = cmd_data[ISTR_WIDTH-1:0];
              i_we_d   = 1'b1;
              state_d  = S_WRITE;
            end
            OP_WD: begin
              d_addr_d = cmd_addr[7:0];
              d_din_d  = cmd_data;
              d_we_d   = 1'b1;
              state_d  = S_WRITE;
            end
            OP_RUN: begin
              n_d     = cmd_data[CNT_WIDTH-1:0];
              slots_d = '0;
              phase_d = 2'd0;
              wait_d  = '0;
              state_d = S_CLEAR;
            end
            default: err_d = 1'b1;
          endcase
        end
      end
      S_WRITE: state_d = S_IDLE;
      S_CLEAR: begin
        wait_d = wait_q + WAIT_W'(1);
        if (wait_q == WAIT_W'(1)) state_d = S_RUN;
      end
      S_RUN: begin
        phase_d = phase_q + 2'd1;
        if (accept && !stop_now) err_d = 1'b1;
        if (stop_now) stop_pend_d = 1'b1;
        // Exits only on a slot boundary so the fetch slot in flight completes.
        if (phase_q == 2'd3) begin
          slots_d = slots_q + CNT_WIDTH'(1);
          if (stop_pend_q || stop_now || last_slot) begin
            wait_d  = '0;
            state_d = S_DRAIN;
          end
        end
      end
      S_DRAIN: begin
        wait_d = wait_q + WAIT_W'(1);
        if (wait_q == WAIT_W'(DRAIN_CYCLES - 1)) state_d = S_DONE;
      end
      S_DONE: begin
        stop_pend_d = 1'b0;
        state_d     = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with it.
  always_comb begin
    cmd_ready_d = (state_d == S_IDLE) || (state_d == S_RUN);
    pc_en_d     = (state_d == S_RUN);
    rstn_d      = (state_d != S_CLEAR);
    busy_d      = (state_d != S_IDLE);
    done_d      = (state_d == S_DONE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      wait_q      <= '0;
      phase_q     <= 2'd0;
      n_q         <= '0;
      slots_q     <= '0;
      stop_pend_q <= 1'b0;
      cmd_ready_q <= 1'b0;
      i_addr_q    <= '0;
      i_din_q     <= '0;
      i_we_q      <= 1'b0;
      d_addr_q    <= '0;
      d_din_q     <= '0;
      d_we_q      <= 1'b0;
      pc_en_q     <= 1'b0;
      rstn_q      <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      wait_q      <= wait_d;
      phase_q     <= phase_d;
      n_q         <= n_d;
      slots_q     <= slots_d;
      stop_pend_q <= stop_pend_d;
      cmd_ready_q <= cmd_ready_d;
      i_addr_q    <= i_addr_d;
      i_din_q     <= i_din_d;
      i_we_q      <= i_we_d;
      d_addr_q    <= d_addr_d;
      d_din_q     <= d_din_d;
      d_we_q      <= d_we_d;
      pc_en_q     <= pc_en_d;
      rstn_q      <= rstn_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  assign cmd_ready   = cmd_ready_q;
  assign i_mem_addra = i_addr_q;
  assign i_mem_din   = i_din_q;
  assign i_mem_we    = i_we_q;
  assign d_mem_addra = d_addr_q;
  assign d_mem_din   = d_din_q;
  assign d_mem_we    = d_we_q;
  assign pc_en       = pc_en_q;
  assign dp_reset_n  = rstn_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign err         = err_q;
  assign slots_run   = slots_q;

endmodule

// File: tb/tb_dp_seq_ctrl.sv
// Randomized scoreboard bench for dp_seq_ctrl; expected pulses come from a
// slot-arithmetic model of the run/stop/drain timing.
module tb_dp_seq_ctrl;
  localparam int D = 4;
  localparam int K_WI = 0, K_WD = 1, K_ER = 2, K_DN = 3;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [1:0]  cmd_op = 2'b00;
  logic [31:0] cmd_addr = '0;
  logic [63:0] cmd_data = '0;
  logic [31:0] i_mem_addra;
  logic [31:0] i_mem_din;
  logic        i_mem_we;
  logic [7:0]  d_mem_addra;
  logic [63:0] d_mem_din;
  logic        d_mem_we;
  logic        pc_en, dp_reset_n, busy, done, err;
  logic [15:0] slots_run;

  dp_seq_ctrl #(.PC_WIDTH(32), .ISTR_WIDTH(32), .D_WIDTH(64), .CNT_WIDTH(16),
                .DRAIN_CYCLES(D)) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_addr(cmd_addr), .cmd_data(cmd_data),
    .i_mem_addra(i_mem_addra), .i_mem_din(i_mem_din), .i_mem_we(i_mem_we),
    .d_mem_addra(d_mem_addra), .d_mem_din(d_mem_din), .d_mem_we(d_mem_we),
    .pc_en(pc_en), .dp_reset_n(dp_reset_n), .busy(busy), .done(done),
    .err(err), .slots_run(slots_run));

  always #5 clk = ~clk;

  int edges = 0;
  always @(posedge clk) edges <= edges + 1;

  typedef struct {
    int          kind;
    int          cyc;
    logic [63:0] v1;
    logic [63:0] v2;
  } ev_t;
  ev_t sbq[$];

  int total = 0;
  int bad = 0;
  int idle_edge = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic string kname(input int k);
    case (k)
      K_WI: return "imem_we";
      K_WD: return "dmem_we";
      K_ER: return "err";
      default: return "done";
    endcase
  endfunction

  function automatic int imin(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  task automatic push(input int k, input int cyc, input logic [63:0] v1, input logic [63:0] v2);
    ev_t e;
    e.kind = k; e.cyc = cyc; e.v1 = v1; e.v2 = v2;
    sbq.push_back(e);
  endtask

  task automatic match(input int k, input logic [63:0] v1, input logic [63:0] v2);
    int idx = -1;
    for (int i = 0; i < sbq.size(); i++)
      if (idx < 0 && sbq[i].kind == k) idx = i;
    if (idx < 0) begin
      total++;
      bad++;
      $display("FAIL unexpected_%s: got pulse at cycle %0d want none", kname(k), edges + 1);
    end else begin
      chk({kname(k), "_cycle"}, 64'(edges + 1), 64'(sbq[idx].cyc));
      chk({kname(k), "_v1"}, v1, sbq[idx].v1);
      chk({kname(k), "_v2"}, v2, sbq[idx].v2);
      sbq.delete(idx);
    end
  endtask

  // Monitor: every output pulse is matched against the scoreboard.
  int pc_cnt = 0;
  always @(negedge clk) begin
    if (reset) pc_cnt = 0;
    else begin
      if (pc_en) pc_cnt++;
      if (i_mem_we) match(K_WI, 64'(i_mem_addra), 64'(i_mem_din));
      if (d_mem_we) match(K_WD, 64'(d_mem_addra), d_mem_din);
      if (err) match(K_ER, 64'd0, 64'd0);
      if (done) begin
        match(K_DN, 64'(slots_run), 64'(pc_cnt));
        pc_cnt = 0;
      end
    end
  end

  // Called 1 time unit after a posedge; returns the edge of acceptance.
  task automatic send(input logic [1:0] op, input logic [31:0] addr, input logic [63:0] data,
                      input int at_edge, output int acc);
    int guard = 0;
    logic rdy;
    if (at_edge < edges + 1) at_edge = edges + 1;
    while (edges < at_edge - 1) begin @(posedge clk); #1; end
    cmd_valid = 1'b1; cmd_op = op; cmd_addr = addr; cmd_data = data;
    acc = -1;
    while (acc < 0 && guard < 200) begin
      rdy = cmd_ready;
      @(posedge clk); #1;
      if (rdy) acc = edges;
      guard++;
    end
    cmd_valid = 1'b0;
    if (acc < 0) begin
      total++;
      bad++;
      $display("FAIL handshake: got no accept want accept at edge %0d", at_edge);
      acc = edges;
    end
    chk("accept_edge", 64'(acc), 64'(at_edge));
  endtask

  task automatic do_write(input bit imem, input logic [31:0] addr, input logic [63:0] data);
    int t;
    send(imem ? 2'b00 : 2'b01, addr, data, idle_edge, t);
    if (imem) push(K_WI, t + 1, 64'(addr), 64'(data[31:0]));
    else      push(K_WD, t + 1, 64'(addr[7:0]), data);
    chk("write_ready_low", 64'(cmd_ready), 64'd0);
    chk("write_busy", 64'(busy), 64'd1);
    idle_edge = t + 2;
  endtask

  task automatic do_badstop();
    int t;
    send(2'b11, $urandom, 64'd0, idle_edge, t);
    push(K_ER, t + 1, 64'd0, 64'd0);
    chk("idle_stop_busy", 64'(busy), 64'd0);
    chk("idle_stop_ready", 64'(cmd_ready), 64'd1);
    idle_edge = t + 1;
  endtask

  // Run N slots; optional illegal command and stop at offsets into RUN.
  task automatic do_run(input int n, input bit ill, input int w_off, input bit stp, input int s_off);
    int t, w, s, p, acc, bud, exit_e, lo, nslots;
    send(2'b10, $urandom, {32'($urandom), 16'($urandom), 16'(n)}, idle_edge, t);
    chk("clear_rstn_1", 64'(dp_reset_n), 64'd0);
    chk("clear_pcen", 64'(pc_en), 64'd0);
    chk("clear_busy", 64'(busy), 64'd1);
    chk("clear_slots", 64'(slots_run), 64'd0);
    @(posedge clk); #1;
    chk("clear_rstn_2", 64'(dp_reset_n), 64'd0);
    bud = (n != 0) ? t + 2 + 4 * n : 32'h7fff_ffff;
    exit_e = bud;
    lo = t + 3;
    if (ill) begin
      w = imin(lo + w_off, bud);
      send(2'($urandom_range(0, 2)), $urandom, {$urandom, $urandom}, w, acc);
      push(K_ER, acc + 1, 64'd0, 64'd0);
      lo = acc + 1;
    end
    if (stp && lo <= bud) begin
      s = imin(lo + s_off, bud);
      send(2'b11, $urandom, 64'd0, s, acc);
      p = (acc - (t + 3)) % 4;
      exit_e = imin(bud, acc + 3 - p);
    end
    nslots = (exit_e - t - 2) / 4;
    push(K_DN, exit_e + 1 + D, 64'(nslots), 64'(exit_e - t - 2));
    while (edges < exit_e + 1 + D) begin @(posedge clk); #1; end
    chk("post_run_slots", 64'(slots_run), 64'(nslots));
    chk("post_run_busy", 64'(busy), 64'd0);
    idle_edge = exit_e + 2 + D;
  endtask

  initial begin
    int t, n, r;
    bit stp;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_rstn", 64'(dp_reset_n), 64'd0);
    chk("rst_ready", 64'(cmd_ready), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_pcen", 64'(pc_en), 64'd0);
    chk("rst_pulses", {60'd0, i_mem_we, d_mem_we, done, err}, 64'd0);
    chk("rst_slots", 64'(slots_run), 64'd0);
    reset = 1'b0;
    @(posedge clk); #1;
    chk("idle_ready", 64'(cmd_ready), 64'd1);
    chk("idle_rstn", 64'(dp_reset_n), 64'd1);
    chk("idle_busy", 64'(busy), 64'd0);
    idle_edge = edges + 1;

    do_write(1'b1, 32'd5, 64'h0000_0000_00A0_0093);
    do_write(1'b0, 32'd3, 64'h0000_0000_0000_DEAD);
    do_run(3, 1'b0, 0, 1'b0, 0);
    do_run(0, 1'b0, 0, 1'b1, 1);
    do_run(0, 1'b0, 0, 1'b1, 5);
    do_run(2, 1'b1, 2, 1'b0, 0);
    do_badstop();

    for (int i = 0; i < 30; i++) begin
      r = $urandom_range(0, 7);
      if (r < 2) do_write(1'b1, $urandom, {$urandom, $urandom});
      else if (r < 4) do_write(1'b0, $urandom, {$urandom, $urandom});
      else if (r == 4) do_badstop();
      else begin
        n = $urandom_range(0, 4);
        stp = (n == 0) || ($urandom_range(0, 1) == 1);
        do_run(n, 1'($urandom_range(0, 1)), $urandom_range(0, 9), stp, $urandom_range(0, 12));
      end
    end

    // Asynchronous reset in the middle of a run.
    send(2'b10, 32'd0, 64'd5, idle_edge, t);
    while (edges < t + 8) begin @(posedge clk); #1; end
    #2;
    reset = 1'b1;
    #1;
    chk("midrst_pcen", 64'(pc_en), 64'd0);
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_rstn", 64'(dp_reset_n), 64'd0);
    chk("midrst_slots", 64'(slots_run), 64'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    idle_edge = edges + 1;
    do_run(1, 1'b0, 0, 1'b0, 0);

    repeat (10) @(posedge clk);
    #1;
    chk("scoreboard_empty", 64'(sbq.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: got no finish want finish by 300000");
    $fatal(1, "watchdog expired");
  end

endmodule
